// File: rtl/cache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm_pkg
// Purpose  : Shared definitions for the cache-miss fill controller:
//            state encoding, block geometry and index widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cache_fill_fsm_pkg;

  // Fill controller state encoding
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Block geometry: 8 words of 16 bits, so 16 bytes per block
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLK_OFFSET_W    = 4;
  localparam int WORD_IDX_W      = 3;

  // Index of the last word in a block, sized to the word counters
  localparam logic [WORD_IDX_W-1:0] LAST_WORD_IDX = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

endpackage : cache_fill_fsm_pkg
`default_nettype wire

// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm_if
// Purpose  : Handshake bundle between the cache-side logic / main memory
//            (master) and the fill controller (slave).
// Signals  : miss_detected, miss_address, memory_data_valid  (master -> fsm)
//            fsm_busy, write_data_array, write_tag_array,
//            Word_Num, memory_address, mem_req               (fsm -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16
) ();
  import cache_fill_fsm_pkg::*;

  logic                  miss_detected;
  logic [ADDR_W-1:0]     miss_address;
  logic                  memory_data_valid;
  logic                  fsm_busy;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [WORD_IDX_W-1:0] Word_Num;
  logic [ADDR_W-1:0]     memory_address;
  logic                  mem_req;

  // Cache-side / memory end of the handshake
  modport master (
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, write_data_array, write_tag_array,
           Word_Num, memory_address, mem_req
  );

  // Fill controller end of the handshake
  modport slave (
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, write_data_array, write_tag_array,
           Word_Num, memory_address, mem_req
  );

endinterface : cache_fill_fsm_if
`default_nettype wire

// File: rtl/cache_fill_fsm_fill_word_counter.sv
`default_nettype none
// ============================================================================
// Module   : fill_word_counter
// Purpose  : 3-bit word counter for one side (issue or receive) of a fill.
//            Synchronous clear, count enable, and a flag when the count
//            reaches the last word of the block.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            clr         - clear to 0 (start of a new fill)
//            en          - advance by one word
//            count       - current word index
//            last        - count is at the last word of the block
// Revision : 1.0 - initial release
// ============================================================================
module fill_word_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_IDX_W-1:0] count,
  output logic                  last
);

  assign last = (count == LAST_WORD_IDX);

  // Saturates at the last word so the index never wraps within a fill;
  // the issue side relies on this to hold 7 once all reads are out.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule : fill_word_counter
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Cache-miss fill controller shared by the I- and D-cache.
//            Latches the missing block, issues 8 sequential word reads to
//            pipelined main memory, steers each returned word into the data
//            array and writes the tag when the final word lands.
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset
//            bus  - cache_fill_fsm_if.slave handshake bundle
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  cache_fill_fsm_if.slave    bus
);

  localparam int BLK_W = ADDR_W - BLK_OFFSET_W;

  fill_state_t           state;
  fill_state_t           state_nxt;
  logic [BLK_W-1:0]      blk;
  logic                  issue_done;
  logic [WORD_IDX_W-1:0] issue_cnt;
  logic                  issue_last;
  logic [WORD_IDX_W-1:0] rx_cnt;
  logic                  rx_last;
  logic                  start_fill;
  logic                  issue_fire;
  logic                  rx_fire;

  logic                  busy;
  logic                  wr_data;
  logic                  wr_tag;
  logic                  req;
  logic [WORD_IDX_W-1:0] word_num;

  // A fill only starts from IDLE; the completion cycle is still FILL, so a
  // persisting miss there is picked up one IDLE cycle later.
  assign start_fill = (state == IDLE) && bus.miss_detected;
  assign issue_fire = (state == FILL) && !issue_done;
  assign rx_fire    = (state == FILL) && bus.memory_data_valid;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Block address latch and issue-complete flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      blk        <= '0;
      issue_done <= 1'b0;
    end else if (start_fill) begin
      blk        <= bus.miss_address[ADDR_W-1:BLK_OFFSET_W];
      issue_done <= 1'b0;
    end else if (issue_fire && issue_last) begin
      issue_done <= 1'b1;
    end
  end

  fill_word_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_fill),
    .en    (issue_fire),
    .count (issue_cnt),
    .last  (issue_last)
  );

  fill_word_counter u_rx_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_fill),
    .en    (rx_fire),
    .count (rx_cnt),
    .last  (rx_last)
  );

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    wr_data   = 1'b0;
    wr_tag    = 1'b0;
    req       = 1'b0;
    word_num  = '0;
    case (state)
      IDLE: begin
        if (bus.miss_detected) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        busy     = 1'b1;
        req      = !issue_done;
        word_num = rx_cnt;
        if (bus.memory_data_valid) begin
          wr_data = 1'b1;
          if (rx_last) begin
            wr_tag    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counters and block register are only cleared on entering FILL, so in
  // IDLE this naturally holds the last issued address (0 after reset).
  assign bus.memory_address   = {blk, issue_cnt, 1'b0};
  assign bus.fsm_busy         = busy;
  assign bus.write_data_array = wr_data;
  assign bus.write_tag_array  = wr_tag;
  assign bus.mem_req          = req;
  assign bus.Word_Num         = word_num;

endmodule : cache_fill_fsm
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Self-checking bench for cache_fill_fsm. A pipelined memory model
//            returns words a fixed latency after each request (optionally
//            gated by a gap pattern); expected addresses and word indices are
//            queued when a miss is accepted and popped as the DUT responds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

  logic clk;
  logic rst;

  cache_fill_fsm_if #(.ADDR_W(16)) bus ();

  cache_fill_fsm #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Reference model state
  bit          m_fill    = 1'b0;
  logic [15:0] last_addr = 16'h0000;
  logic [15:0] exp_addr[$];
  logic [2:0]  exp_words[$];
  int          due[$];
  int          mem_lat   = 4;
  bit          gap_en    = 1'b0;
  int          gap_idx   = 0;
  bit [5:0]    gap_pat   = 6'b011001;  // 1,0,0,1,1,0 from bit 0 upward

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic tick(input bit m, input logic [15:0] a, input bit r, input bit stray);
    bit          vld;
    bit          exp_tag;
    logic [15:0] ea;
    logic [2:0]  ew;
    rst                  = r;
    bus.miss_detected    = m;
    bus.miss_address     = a;
    vld                  = stray;
    if (!stray && due.size() > 0) begin
      if (due[0] <= cyc_n && (!gap_en || gap_pat[gap_idx])) vld = 1'b1;
    end
    bus.memory_data_valid = vld;
    #3;
    exp_tag = 1'b0;
    if (!r) begin
      chk("fsm_busy", {15'd0, bus.fsm_busy}, {15'd0, m_fill});
      if (m_fill) begin
        chk("mem_req", {15'd0, bus.mem_req}, {15'd0, exp_addr.size() != 0});
        if (exp_addr.size() != 0) begin
          ea = exp_addr.pop_front();
          chk("mem_addr", bus.memory_address, ea);
          last_addr = ea;
          due.push_back(cyc_n + mem_lat);
        end
        chk("wr_data", {15'd0, bus.write_data_array}, {15'd0, vld});
        if (vld) begin
          void'(due.pop_front());
          if (exp_words.size() != 0) begin
            ew = exp_words.pop_front();
            chk("word_num", {13'd0, bus.Word_Num}, {13'd0, ew});
            exp_tag = (exp_words.size() == 0);
          end
        end
        chk("wr_tag", {15'd0, bus.write_tag_array}, {15'd0, exp_tag});
      end else begin
        chk("idle_req",  {15'd0, bus.mem_req}, 16'd0);
        chk("idle_wd",   {15'd0, bus.write_data_array}, 16'd0);
        chk("idle_tag",  {15'd0, bus.write_tag_array}, 16'd0);
        chk("idle_word", {13'd0, bus.Word_Num}, 16'd0);
        chk("idle_addr", bus.memory_address, last_addr);
      end
    end
    // Model state update
    if (r) begin
      m_fill    = 1'b0;
      last_addr = 16'h0000;
      exp_addr.delete();
      exp_words.delete();
      due.delete();
    end else if (!m_fill && m) begin
      m_fill = 1'b1;
      for (int i = 0; i < 8; i++) begin
        exp_addr.push_back({a[15:4], 3'(i), 1'b0});
        exp_words.push_back(3'(i));
      end
    end else if (m_fill && exp_tag) begin
      m_fill = 1'b0;
    end
    if (gap_en) gap_idx = (gap_idx + 1) % 6;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Run the remainder of an accepted fill, bounded by a cycle budget.
  task automatic run_fill(input int budget, input bit hold, input logic [15:0] haddr,
                          output int len);
    int n;
    n = 0;
    while (m_fill && n < budget) begin
      tick(hold, haddr, 1'b0, 1'b0);
      n++;
    end
    len = n;
    chk("fill_timeout", {15'd0, m_fill}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst                   = 1'b1;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0000;
    bus.memory_data_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset wins over a pending miss and stray valid
    repeat (3) tick(1'b1, 16'h1234, 1'b1, 1'b1);
    repeat (2) tick(1'b0, 16'h0000, 1'b0, 1'b0);

    // Single miss, L=4, no gaps: completes 12 cycles after the miss
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    run_fill(40, 1'b0, 16'h1234, len);
    chk("fill_len_basic", 16'(len), 16'd12);
    tick(1'b0, 16'h0000, 1'b0, 1'b0);

    // Miss held two cycles, then dropped with a new address at cycle 3
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    run_fill(40, 1'b0, 16'hABCD, len);
    chk("fill_len_addrchg", 16'(len), 16'd10);
    tick(1'b0, 16'hABCD, 1'b0, 1'b0);

    // Gapped returns
    gap_en  = 1'b1;
    gap_idx = 0;
    tick(1'b1, 16'h5678, 1'b0, 1'b0);
    run_fill(80, 1'b0, 16'h5678, len);
    gap_en = 1'b0;
    tick(1'b0, 16'h0000, 1'b0, 1'b0);

    // Reset at cycle 7 of a fill, then stray valids in IDLE
    tick(1'b1, 16'h9990, 1'b0, 1'b0);
    repeat (6) tick(1'b0, 16'h9990, 1'b0, 1'b0);
    tick(1'b0, 16'h9990, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 16'h0000, 1'b0, 1'b1);
    tick(1'b1, 16'h2000, 1'b0, 1'b0);
    run_fill(40, 1'b0, 16'h2000, len);
    chk("fill_len_after_rst", 16'(len), 16'd12);

    // Miss held through completion: one IDLE cycle, then refill at 0x4000
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    run_fill(40, 1'b1, 16'h4000, len);
    chk("fill_len_held", 16'(len), 16'd12);
    tick(1'b1, 16'h4000, 1'b0, 1'b0);
    run_fill(40, 1'b0, 16'h4000, len);
    chk("fill_len_refill", 16'(len), 16'd12);
    repeat (2) tick(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cache_fill_fsm
`default_nettype wire
